imem_loader: RTL



---
 rtl/loader_pkg.sv | 11 +
 rtl/imem_loader_packer.sv | 34 +++
 rtl/imem_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states and
// stream field geometry.
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int LEN_BYTES = 4;
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = LEN_BYTES * BYTE_W;
endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word assembler. o_word_valid pulses combinationally
// on the transfer of the 4th byte; o_word carries that byte in the top lane.
module byte_to_word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic              i_ready,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);
  logic [1:0]               r_cnt;
  logic [WORD_W-BYTE_W-1:0] r_buf;
  logic                     w_xfer;

  // A byte arriving alongside a clear belongs to the aborted load.
  assign w_xfer = i_valid & i_ready & ~i_clr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 2'd1;
      r_buf <= {i_data, r_buf[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  assign o_word_valid = w_xfer && (r_cnt == 2'd3);
  assign o_word       = {i_data, r_buf};
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN / N words / XOR checksum from a byte stream, writes
// the words to instruction memory and releases the CPU once verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam logic [WORD_W:0]     MAX_N = ((WORD_W+1)'(1) << ADDR_WIDTH) - (WORD_W+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   ONE  = (ADDR_WIDTH+1)'(1);

  state_t                r_state, w_next;
  logic                  w_word_valid;
  logic [WORD_W-1:0]     w_word;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_W-1:0]     r_wdata;
  logic [WORD_W-1:0]     r_xor;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [ADDR_WIDTH:0]   r_len;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (start),
    .i_valid      (in_valid),
    .i_ready      (in_ready),
    .i_data       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_LEN;
    end else begin
      case (r_state)
        S_LEN:
          if (w_word_valid) begin
            if ({1'b0, w_word} > MAX_N) w_next = S_ERR;
            else if (w_word == '0)      w_next = S_CSUM;
            else                        w_next = S_DATA;
          end
        S_DATA:
          if (w_word_valid && (r_idx + ONE == r_len)) w_next = S_CSUM;
        S_CSUM:
          if (w_word_valid) w_next = (w_word == r_xor) ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end

  // done/error/cpu_hold follow the registered state, so they change the
  // cycle after the deciding byte.
  always_comb begin
    in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    done     = (r_state == S_DONE);
    error    = (r_state == S_ERR);
    cpu_hold = (r_state != S_DONE);
  end

  // The length check bounds r_idx, so BASE + r_idx never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_xor   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_xor <= '0;
        r_idx <= '0;
      end else if (w_word_valid) begin
        if (r_state == S_LEN) r_len <= w_word[ADDR_WIDTH:0];
        if (r_state == S_DATA) begin
          r_we    <= 1'b1;
          r_addr  <= BASE + r_idx[ADDR_WIDTH-1:0];
          r_wdata <= w_word;
          r_xor   <= r_xor ^ w_word;
          r_idx   <= r_idx + ONE;
        end
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_idx;
endmodule
